// File: rtl/cga_vram_arbiter.sv
// -----------------------------------------------------------------------------
// cga_vram_arbiter
//
// Shares the single-port video SRAM between the CGA display fetch and CPU
// byte/word accesses to the 32 KB CGA window (SRAM 0x08000-0x0FFFF with the
// default VRAM_PAGE). Display fetches own every cycle with vid_read high; CPU
// byte phases are slotted into the remaining cycles, so the CPU stalls rather
// than disturbing the picture.
//
// Build option:
//   CGA_SNOW_EN - CPU phases take the SRAM even in display cycles (fixed CPU
//                 latency); the display then latches the CPU byte, which
//                 reproduces the original CGA "snow" artefact.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   vid_read, vid_addr      display fetch strobe and address
//   vid_data                registered fetched byte (1 cycle after fetch)
//   cpu_req                 level request, held until cpu_ack
//   cpu_we, cpu_word        write / 16-bit select, latched at accept
//   cpu_addr, cpu_wdata     window byte offset / little-endian write data
//   cpu_rdata, cpu_ack      read data (held until next read) / done pulse
//   sram_a, sram_d_out      SRAM address / write data
//   sram_d_in               SRAM read data (valid within the cycle)
//   sram_we_l, sram_oe_l    active-low write / output enables
// -----------------------------------------------------------------------------
module cga_vram_arbiter #(
    parameter logic [3:0] VRAM_PAGE = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_read,
    input  logic [18:0] vid_addr,
    output logic [7:0]  vid_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_word,
    input  logic [14:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic [18:0] sram_a,
    output logic [7:0]  sram_d_out,
    input  logic [7:0]  sram_d_in,
    output logic        sram_we_l,
    output logic        sram_oe_l
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic        we_r;
    logic        word_r;
    logic [14:0] addr_r;
    logic [15:0] wdata_r;

    logic [15:0] cpu_rdata_r;
    logic        cpu_ack_r;
    logic [7:0]  vid_data_r;

    logic        in_phase_s;
    logic        slot_go_s;
    logic [14:0] phase_addr_s;
    logic [7:0]  phase_byte_s;

    logic [18:0] sram_a_s;
    logic [7:0]  sram_d_out_s;
    logic        sram_we_l_s;
    logic        sram_oe_l_s;

    assign in_phase_s = (state_r == BYTE0) || (state_r == BYTE1);

`ifdef CGA_SNOW_EN
    // CPU phase always takes the SRAM, even over a display fetch.
    assign slot_go_s = in_phase_s;
`else
    // CPU phase only advances in a cycle the display does not own.
    assign slot_go_s = in_phase_s && !vid_read;
`endif

    // High byte lives at the next offset; 15-bit add wraps 0x7FFF to 0x0000.
    assign phase_addr_s = (state_r == BYTE1) ? (addr_r + 15'd1) : addr_r;
    assign phase_byte_s = (state_r == BYTE1) ? wdata_r[15:8] : wdata_r[7:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (cpu_req) begin
                    state_next_s = BYTE0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BYTE0: begin
                if (slot_go_s) begin
                    state_next_s = word_r ? BYTE1 : ACK;
                end else begin
                    state_next_s = BYTE0;
                end
            end
            BYTE1: begin
                if (slot_go_s) begin
                    state_next_s = ACK;
                end else begin
                    state_next_s = BYTE1;
                end
            end
            ACK: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // SRAM control: display address by default, CPU phase address in a slot.
    always_comb begin
        sram_a_s     = vid_addr;
        sram_d_out_s = 8'h00;
        sram_we_l_s  = 1'b1;
        sram_oe_l_s  = 1'b0;
        if (slot_go_s) begin
            sram_a_s = {VRAM_PAGE, phase_addr_s};
            if (we_r) begin
                sram_we_l_s  = 1'b0;
                sram_oe_l_s  = 1'b1;
                sram_d_out_s = phase_byte_s;
            end else begin
                sram_we_l_s  = 1'b1;
                sram_oe_l_s  = 1'b0;
                sram_d_out_s = 8'h00;
            end
        end else begin
            sram_a_s     = vid_addr;
            sram_d_out_s = 8'h00;
            sram_we_l_s  = 1'b1;
            sram_oe_l_s  = 1'b0;
        end
    end

    // Latch the CPU request when it is accepted from IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r    <= 1'b0;
            word_r  <= 1'b0;
            addr_r  <= 15'h0000;
            wdata_r <= 16'h0000;
        end else if ((state_r == IDLE) && cpu_req) begin
            we_r    <= cpu_we;
            word_r  <= cpu_word;
            addr_r  <= cpu_addr;
            wdata_r <= cpu_wdata;
        end else begin
            we_r    <= we_r;
            word_r  <= word_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // CPU completion pulse and read-data capture into the phase's byte lane.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_ack_r   <= 1'b0;
            cpu_rdata_r <= 16'h0000;
        end else begin
            cpu_ack_r <= (state_next_s == ACK);
            if (slot_go_s && !we_r) begin
                if (state_r == BYTE1) begin
                    cpu_rdata_r[15:8] <= sram_d_in;
                end else begin
                    cpu_rdata_r[7:0] <= sram_d_in;
                end
            end else begin
                cpu_rdata_r <= cpu_rdata_r;
            end
        end
    end

    // Display byte capture. A write can only own a display cycle with snow
    // enabled, and then the display sees the byte being written.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_data_r <= 8'h00;
        end else if (vid_read) begin
            vid_data_r <= sram_we_l_s ? sram_d_in : sram_d_out_s;
        end else begin
            vid_data_r <= vid_data_r;
        end
    end

    assign vid_data   = vid_data_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign cpu_ack    = cpu_ack_r;
    assign sram_a     = sram_a_s;
    assign sram_d_out = sram_d_out_s;
    assign sram_we_l  = sram_we_l_s;
    assign sram_oe_l  = sram_oe_l_s;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cga_vram_arbiter
//
// Directed bench for cga_vram_arbiter: a per-cycle vector table for the
// uncontended byte write / word read / display fetch paths, then hand-written
// sequences for display contention, reset in mid-access and (with
// CGA_SNOW_EN) snow behaviour. A small byte-wide SRAM model sits on the bus.
// -----------------------------------------------------------------------------
module tb_cga_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        vid_read;
    logic [18:0] vid_addr;
    logic [7:0]  vid_data;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_word;
    logic [14:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic [18:0] sram_a;
    logic [7:0]  sram_d_out;
    logic [7:0]  sram_d_in;
    logic        sram_we_l;
    logic        sram_oe_l;

    logic [7:0]  mem [0:524287];
    logic        pre_en;
    logic [18:0] pre_addr;
    logic [7:0]  pre_data;

    int n_vec;
    int n_err;

    typedef struct {
        logic        vr;
        logic [18:0] va;
        logic        req;
        logic        we;
        logic        word;
        logic [14:0] addr;
        logic [15:0] wd;
        logic        e_ack;
        logic [18:0] e_a;
        logic        e_we_l;
        logic        e_oe_l;
        logic [7:0]  e_dout;
        logic        chk_rd;
        logic [15:0] e_rd;
        logic        chk_vd;
        logic [7:0]  e_vd;
    } vec_t;

    vec_t vecs [0:12];

    cga_vram_arbiter #(.VRAM_PAGE(4'b0001)) dut (
        .clk        (clk),
        .reset      (reset),
        .vid_read   (vid_read),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_word   (cpu_word),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .sram_a     (sram_a),
        .sram_d_out (sram_d_out),
        .sram_d_in  (sram_d_in),
        .sram_we_l  (sram_we_l),
        .sram_oe_l  (sram_oe_l)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Asynchronous-read SRAM model.
    assign sram_d_in = mem[sram_a];

    // SRAM write port, with a bench-only preload path used in idle cycles.
    always @(posedge clk) begin
        if (!sram_we_l) begin
            mem[sram_a] <= sram_d_out;
        end else if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Advance to the next cycle and drive inputs 1 unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [18:0] a, input logic [7:0] d);
        next_cycle();
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        next_cycle();
        pre_en   = 1'b0;
    endtask

    task automatic drive(input logic vr, input logic [18:0] va, input logic req,
                         input logic we, input logic word, input logic [14:0] a,
                         input logic [15:0] wd);
        vid_read  = vr;
        vid_addr  = va;
        cpu_req   = req;
        cpu_we    = we;
        cpu_word  = word;
        cpu_addr  = a;
        cpu_wdata = wd;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        pre_en   = 1'b0;
        pre_addr = 19'h00000;
        pre_data = 8'h00;
        reset    = 1'b1;
        drive(1'b0, 19'h00040, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);

        // Byte write 0x00A5 at 0x0123, uncontended.
        vecs[0]  = '{1'b0, 19'h00040, 1'b1, 1'b1, 1'b0, 15'h0123, 16'h00A5,
                     1'b0, 19'h00040, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 19'h00040, 1'b1, 1'b1, 1'b0, 15'h0123, 16'h00A5,
                     1'b0, 19'h08123, 1'b0, 1'b1, 8'hA5, 1'b1, 16'h0000, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 19'h00040, 1'b1, 1'b1, 1'b0, 15'h0123, 16'h00A5,
                     1'b1, 19'h00040, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 19'h00040, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000,
                     1'b0, 19'h00040, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00};
        // Word read at 0x7FFF: high byte wraps to offset 0x0000.
        vecs[4]  = '{1'b0, 19'h00050, 1'b1, 1'b0, 1'b1, 15'h7FFF, 16'h0000,
                     1'b0, 19'h00050, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 19'h00050, 1'b1, 1'b0, 1'b1, 15'h7FFF, 16'h0000,
                     1'b0, 19'h0FFFF, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 19'h00050, 1'b1, 1'b0, 1'b1, 15'h7FFF, 16'h0000,
                     1'b0, 19'h08000, 1'b1, 1'b0, 8'h00, 1'b1, 16'h0034, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 19'h00050, 1'b1, 1'b0, 1'b1, 15'h7FFF, 16'h0000,
                     1'b1, 19'h00050, 1'b1, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 8'h00};
        // Display fetch of the byte written above, then hold.
        vecs[8]  = '{1'b1, 19'h08123, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000,
                     1'b0, 19'h08123, 1'b1, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b1, 8'h00};
        vecs[9]  = '{1'b0, 19'h0FFFF, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000,
                     1'b0, 19'h0FFFF, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'hA5};
        vecs[10] = '{1'b0, 19'h0FFFF, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000,
                     1'b0, 19'h0FFFF, 1'b1, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b1, 8'hA5};
        vecs[11] = '{1'b1, 19'h0FFFF, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000,
                     1'b0, 19'h0FFFF, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'hA5};
        vecs[12] = '{1'b0, 19'h00040, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000,
                     1'b0, 19'h00040, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h34};

        // Reset for two cycles, then check reset state.
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        chk("rst_ack",   32'(cpu_ack),    32'(1'b0));
        chk("rst_rdata", 32'(cpu_rdata),  32'(16'h0000));
        chk("rst_vdata", 32'(vid_data),   32'(8'h00));
        chk("rst_we_l",  32'(sram_we_l),  32'(1'b1));
        chk("rst_oe_l",  32'(sram_oe_l),  32'(1'b0));
        chk("rst_dout",  32'(sram_d_out), 32'(8'h00));

        preload(19'h0FFFF, 8'h34);
        preload(19'h08000, 8'h12);
        preload(19'h08010, 8'h77);
        preload(19'h08200, 8'h11);
        preload(19'h08201, 8'h33);

        for (int i = 0; i < 13; i++) begin
            next_cycle();
            drive(vecs[i].vr, vecs[i].va, vecs[i].req, vecs[i].we, vecs[i].word,
                  vecs[i].addr, vecs[i].wd);
            #1;
            chk($sformatf("v%0d_ack", i),  32'(cpu_ack),   32'(vecs[i].e_ack));
            chk($sformatf("v%0d_a", i),    32'(sram_a),    32'(vecs[i].e_a));
            chk($sformatf("v%0d_we_l", i), 32'(sram_we_l), 32'(vecs[i].e_we_l));
            chk($sformatf("v%0d_oe_l", i), 32'(sram_oe_l), 32'(vecs[i].e_oe_l));
            if (vecs[i].e_we_l == 1'b0) begin
                chk($sformatf("v%0d_dout", i), 32'(sram_d_out), 32'(vecs[i].e_dout));
            end
            if (vecs[i].chk_rd) begin
                chk($sformatf("v%0d_rdata", i), 32'(cpu_rdata), 32'(vecs[i].e_rd));
            end
            if (vecs[i].chk_vd) begin
                chk($sformatf("v%0d_vdata", i), 32'(vid_data), 32'(vecs[i].e_vd));
            end
        end
        chk("mem_08123", 32'(mem[19'h08123]), 32'(8'hA5));

`ifndef CGA_SNOW_EN
        // Byte read of 0x0123 with the display owning cycles 1-5.
        next_cycle();
        drive(1'b0, 19'h08010, 1'b1, 1'b0, 1'b0, 15'h0123, 16'h0000);
        #1;
        chk("c0_ack", 32'(cpu_ack), 32'(1'b0));
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            vid_read = 1'b1;
            #1;
            chk($sformatf("c%0d_a", c),    32'(sram_a),    32'(19'h08010));
            chk($sformatf("c%0d_we_l", c), 32'(sram_we_l), 32'(1'b1));
            chk($sformatf("c%0d_ack", c),  32'(cpu_ack),   32'(1'b0));
            if (c >= 2) begin
                chk($sformatf("c%0d_vdata", c), 32'(vid_data), 32'(8'h77));
            end
        end
        next_cycle();
        vid_read = 1'b0;
        #1;
        chk("c6_a",     32'(sram_a),    32'(19'h08123));
        chk("c6_oe_l",  32'(sram_oe_l), 32'(1'b0));
        chk("c6_we_l",  32'(sram_we_l), 32'(1'b1));
        chk("c6_ack",   32'(cpu_ack),   32'(1'b0));
        chk("c6_vdata", 32'(vid_data),  32'(8'h77));
        next_cycle();
        #1;
        chk("c7_ack",   32'(cpu_ack),        32'(1'b1));
        chk("c7_rdata", 32'(cpu_rdata[7:0]), 32'(8'hA5));
        next_cycle();
        cpu_req = 1'b0;
        #1;
        chk("c8_ack", 32'(cpu_ack), 32'(1'b0));

        // Word write 0xBEEF at 0x0200, reset during the contended BYTE1 cycle.
        next_cycle();
        drive(1'b0, 19'h00060, 1'b1, 1'b1, 1'b1, 15'h0200, 16'hBEEF);
        #1;
        chk("d0_ack", 32'(cpu_ack), 32'(1'b0));
        next_cycle();
        #1;
        chk("d1_a",    32'(sram_a),     32'(19'h08200));
        chk("d1_we_l", 32'(sram_we_l),  32'(1'b0));
        chk("d1_dout", 32'(sram_d_out), 32'(8'hEF));
        next_cycle();
        vid_read = 1'b1;
        reset    = 1'b1;
        #1;
        chk("d2_we_l", 32'(sram_we_l), 32'(1'b1));
        chk("d2_a",    32'(sram_a),    32'(19'h00060));
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 19'h00060, 1'b0, 1'b0, 1'b0, 15'h0000, 16'h0000);
        #1;
        chk("d3_ack",   32'(cpu_ack),   32'(1'b0));
        chk("d3_rdata", 32'(cpu_rdata), 32'(16'h0000));
        chk("d3_a",     32'(sram_a),    32'(19'h00060));
        chk("d3_we_l",  32'(sram_we_l), 32'(1'b1));
        next_cycle();
        #1;
        chk("d4_ack",  32'(cpu_ack),   32'(1'b0));
        chk("d4_a",    32'(sram_a),    32'(19'h00060));
        chk("mem_08200", 32'(mem[19'h08200]), 32'(8'hEF));
        chk("mem_08201", 32'(mem[19'h08201]), 32'(8'h33));
`else
        // Snow: byte write 0x5A takes the SRAM in a display cycle.
        next_cycle();
        drive(1'b0, 19'h08010, 1'b1, 1'b1, 1'b0, 15'h0300, 16'h005A);
        #1;
        chk("s0_ack", 32'(cpu_ack), 32'(1'b0));
        next_cycle();
        vid_read = 1'b1;
        #1;
        chk("s1_a",    32'(sram_a),    32'(19'h08300));
        chk("s1_we_l", 32'(sram_we_l), 32'(1'b0));
        next_cycle();
        vid_read = 1'b0;
        #1;
        chk("s2_ack",   32'(cpu_ack),  32'(1'b1));
        chk("s2_vdata", 32'(vid_data), 32'(8'h5A));
        next_cycle();
        cpu_req = 1'b0;
        #1;
        chk("s3_ack", 32'(cpu_ack), 32'(1'b0));
        chk("mem_08300", 32'(mem[19'h08300]), 32'(8'h5A));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cga_vram_arbiter.md
# cga_vram_arbiter

Single-port arbiter between the CGA display fetch and CPU memory cycles for the shared video SRAM. It sits directly upstream of the CGA core: the core's fetch address and read strobe come in, and the fetched byte is returned on `vid_data`. CPU byte and word accesses to the 32 KB CGA window are interleaved into the cycles the display does not use. Video fetch always has priority, so CPU cycles stall instead of corrupting the display, unless snow emulation is compiled in.

## Interface

Parameters:
- `VRAM_PAGE`, default 4'b0001: upper 4 bits of the 19-bit SRAM address for CPU accesses; the CGA window is at SRAM 0x08000–0x0FFFF.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `vid_read`  in  1  display fetch strobe; high means the SRAM cycle belongs to video.
- `vid_addr`  in  19  display fetch address.
- `vid_data`  out  8  registered fetched byte.
- `cpu_req`  in  1  level request; held high until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; sampled at accept.
- `cpu_word`  in  1  1 = 16-bit access, 0 = byte; sampled at accept.
- `cpu_addr`  in  15  byte offset in the window; sampled at accept.
- `cpu_wdata`  in  16  write data, little-endian; byte access uses [7:0]; sampled at accept.
- `cpu_rdata`  out  16  read data; valid while `cpu_ack` is high and held until the next read completes.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `sram_a`  out  19  SRAM address.
- `sram_d_out`  out  8  SRAM write data.
- `sram_d_in`  in  8  SRAM read data; combinationally valid within the cycle.
- `sram_we_l`  out  1  active-low write enable.
- `sram_oe_l`  out  1  active-low output enable.

## Operation

- FSM states: IDLE, BYTE0, BYTE1, ACK.
- IDLE with `cpu_req`=1:
  - latch `cpu_we`, `cpu_word`, `cpu_addr`, `cpu_wdata`;
  - go to BYTE0.
- BYTE0 and BYTE1 each need one free slot, i.e. a cycle with `vid_read`=0. Without a free slot the state holds.
- Free slot, actions:
  - `sram_a` = {`VRAM_PAGE`, phase address}.
  - Write: `sram_we_l`=0, `sram_oe_l`=1, `sram_d_out` = byte.
  - Read: `sram_oe_l`=0, and `sram_d_in` is registered into the matching `cpu_rdata` byte at the cycle end.
- Free slot, transitions:
  - BYTE0 goes to BYTE1 if word, otherwise to ACK.
  - BYTE1 goes to ACK.
- Phase addresses:
  - BYTE0 uses `cpu_addr`; BYTE1 uses `cpu_addr`+1, modulo 2^15, so 0x7FFF wraps to 0x0000.
  - Low byte maps to [7:0], high byte to [15:8].
- ACK: `cpu_ack`=1 for exactly one cycle, then IDLE. `cpu_req` is not sampled in ACK.
- Video cycles (`vid_read`=1): `sram_a`=`vid_addr`, `sram_oe_l`=0, `sram_we_l`=1. `vid_data` <= `sram_d_in` at the cycle end.
- Non-CPU, non-video cycles (`vid_read`=0 with no slot in use): `sram_a`=`vid_addr`, `sram_oe_l`=0, `sram_we_l`=1, and `vid_data` holds.
- The `sram_*` outputs are combinational from state, the latched request and `vid_read`. `sram_we_l` is never low while `vid_read`=1, except with the snow feature (see Configuration).

## Timing

- Reset values:
  - State = IDLE.
  - `cpu_ack`=0, `cpu_rdata`=0, `vid_data`=0.
  - Latched request cleared.
  - `sram_we_l`=1, `sram_oe_l`=0, `sram_d_out`=0.
- `vid_data` latency: 1 cycle after the `vid_read` cycle.
- Uncontended byte access: `cpu_req` seen at cycle 0, SRAM access at cycle 1, `cpu_ack` at cycle 2.
- Uncontended word access: accesses at cycles 1 and 2, `cpu_ack` at cycle 3.
- Each `vid_read`=1 cycle that overlaps BYTE0/BYTE1 adds exactly one cycle of latency.
- Back-to-back requests are at least 3 cycles apart (byte).
- Reset mid-operation:
  - Any completed phase has already written to SRAM; the pending phase is abandoned.
  - No `cpu_ack` is issued and the state returns to IDLE.
- `cpu_req` dropped before ack: undefined use; the arbiter still completes the latched access and acks.
- `vid_read` rising in the same cycle as accept: accept proceeds; BYTE0 waits.

## Configuration

- `CGA_SNOW_EN` defined:
  - CPU phases ignore `vid_read`: each of BYTE0/BYTE1 completes in one cycle, so latency is fixed (byte ack at 2, word ack at 3).
  - On a conflict cycle the SRAM serves the CPU, and `vid_data` captures the CPU byte: the write byte on writes, `sram_d_in` on reads. This reproduces CGA snow.
- `CGA_SNOW_EN` undefined: video priority as described in Operation; no display corruption.

## Test plan

- Reset held 2 cycles, then released with `vid_read`=0 → `cpu_ack`=0, `cpu_rdata`=0x0000, `vid_data`=0x00, `sram_we_l`=1.
- Byte write, `cpu_addr`=0x0123, `cpu_wdata`=0x00A5, `vid_read`=0 → cycle 1: `sram_a`=0x08123, `sram_d_out`=0xA5, `sram_we_l`=0; cycle 2: `cpu_ack`=1.
- Word read at 0x7FFF, SRAM model returns 0x34 then 0x12 → `sram_a`=0x0FFFF then 0x08000; `cpu_rdata`=0x1234 with `cpu_ack` at cycle 3.
- Byte read with `vid_read`=1 for cycles 1–5 and `vid_addr`=0x08010 → CPU access at cycle 6, `cpu_ack` at cycle 7; `vid_data` matches SRAM[0x08010] from cycle 2 onward; `sram_we_l` stays 1.
- `CGA_SNOW_EN`: byte write of 0x5A with `vid_read`=1 in cycle 1 → `cpu_ack` at cycle 2, `vid_data`=0x5A at cycle 2.
- Word write 0xBEEF at 0x0200, `reset` asserted in the BYTE1 cycle while `vid_read`=1 → SRAM[0x08200]=0xEF, SRAM[0x08201] unchanged, no `cpu_ack`, state IDLE.
